// File: rtl/logic_pkg.sv
// Shared types and the per-bit gate function for the bitwise logic unit.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Evaluated one bit lane at a time; vector users replicate it across WIDTH.
  function automatic logic gate_fn(op_e op, logic x, logic y);
    case (op)
      OP_NOT:  gate_fn = ~x;
      OP_AND:  gate_fn = x & y;
      OP_OR:   gate_fn = x | y;
      OP_NOR:  gate_fn = ~(x | y);
      OP_NAND: gate_fn = ~(x & y);
      OP_XOR:  gate_fn = x ^ y;
      OP_XNOR: gate_fn = ~(x ^ y);
      default: gate_fn = x;
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_gate_vec.sv
// Combinational WIDTH-bit gate: gate_fn applied independently to every bit lane.
module logic_gate_vec
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_z
);

  op_e w_op;
  assign w_op = op_e'(i_op);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign o_z[i] = gate_fn(w_op, i_x[i], i_y[i]);
  end

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with valid/ready handshake and a burst
// accumulate mode that folds several beats into one result.
module logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_accum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_beats
);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  op_e              r_burst_op, w_burst_op_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data, w_load_data;
  logic [CNT_W-1:0] r_out_beats, w_load_beats;
  logic             w_fire, w_load;
  logic [WIDTH-1:0] w_ab, w_accb;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_fire    = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;

  // Beat count only reports; saturation never stops the data fold.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  logic_gate_vec #(.WIDTH(WIDTH)) u_gate_ab (
    .i_op (in_op),
    .i_x  (in_a),
    .i_y  (in_b),
    .o_z  (w_ab)
  );

  logic_gate_vec #(.WIDTH(WIDTH)) u_gate_acc (
    .i_op (r_burst_op),
    .i_x  (r_acc),
    .i_y  (in_b),
    .o_z  (w_accb)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_burst_op_nxt = r_burst_op;
    w_load         = 1'b0;
    w_load_data    = w_ab;
    w_load_beats   = CNT_W'(1);
    if (w_fire) begin
      case (r_state)
        ST_IDLE: begin
          if (in_accum && !in_last) begin
            w_acc_nxt      = w_ab;
            w_burst_op_nxt = op_e'(in_op);
            w_cnt_nxt      = CNT_W'(1);
            w_state_nxt    = ST_ACCUM;
          end else begin
            w_load = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (in_last) begin
            w_load       = 1'b1;
            w_load_data  = w_accb;
            w_load_beats = w_cnt_inc;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_acc_nxt = w_accb;
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_burst_op <= OP_NOT;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_burst_op <= w_burst_op_nxt;
    end
  end

  // A new result wins over the drain, so a same-cycle handshake keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_beats <= w_load_beats;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: directed scenarios plus random traffic
// against a burst-level reference model.
module tb_logic_unit;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_accum, in_last;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [C-1:0] out_beats;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: pending output, and the open burst as op/value/length.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_beats;
  bit           m_inburst;
  logic [2:0]   m_bop;
  logic [W-1:0] m_acc;
  int           m_n;

  logic [W-1:0] single_exp [8];

  logic_unit #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_accum  (in_accum),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gate(logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y);
    case (op)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return ~(x & y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = 0;
    m_data    = '0;
    m_beats   = 0;
    m_inburst = 0;
    m_n       = 0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    in_valid  = 1'($urandom);
    in_op     = 3'($urandom);
    in_a      = W'($urandom);
    in_b      = W'($urandom);
    in_accum  = 1'($urandom);
    in_last   = 1'($urandom);
    out_ready = 1'($urandom);
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data",  32'(out_data),  32'(0));
    chk("rst_out_beats", 32'(out_beats), 32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  // One clock: drive, check ready, clock, advance model, check outputs.
  task automatic beat(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic acc, input logic last,
                      input logic ordy);
    bit accepted, produced;
    in_valid = v; in_op = op; in_a = a; in_b = b;
    in_accum = acc; in_last = last; out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    accepted = v && (!m_valid || ordy);
    produced = 0;
    @(posedge clk);
    #1;
    if (accepted) begin
      if (!m_inburst) begin
        if (acc && !last) begin
          m_inburst = 1; m_bop = op; m_acc = ref_gate(op, a, b); m_n = 1;
        end else begin
          produced = 1; m_data = ref_gate(op, a, b); m_beats = 1;
        end
      end else begin
        m_acc = ref_gate(m_bop, m_acc, b);
        m_n++;
        if (last) begin
          produced = 1; m_data = m_acc; m_beats = (m_n > 15) ? 15 : m_n;
          m_inburst = 0;
        end
      end
    end
    if (produced) m_valid = 1;
    else if (ordy) m_valid = 0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_beats", 32'(out_beats), 32'(m_beats));
    end
  endtask

  initial begin
    logic [W-1:0] held;
    single_exp[0] = 8'h0F; single_exp[1] = 8'hC0; single_exp[2] = 8'hFC; single_exp[3] = 8'h03;
    single_exp[4] = 8'h3F; single_exp[5] = 8'h3C; single_exp[6] = 8'hC3; single_exp[7] = 8'hF0;

    #2;
    do_reset(3);

    // Single beats, all eight ops back-to-back
    for (int op = 0; op < 8; op++) begin
      beat(1'b1, 3'(op), 8'hF0, 8'hCC, 1'b0, 1'b0, 1'b1);
      chk("single_op", 32'(out_data), 32'(single_exp[op]));
    end
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // XOR accumulate burst; in_op/in_a on later beats must be ignored
    beat(1'b1, 3'd5, 8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
    chk("burst_novalid1", 32'(out_valid), 32'(0));
    beat(1'b1, 3'd1, 8'h55, 8'h04, 1'b0, 1'b0, 1'b1);
    chk("burst_novalid2", 32'(out_valid), 32'(0));
    beat(1'b1, 3'd3, 8'hAA, 8'h08, 1'b1, 1'b1, 1'b1);
    chk("burst_data",  32'(out_data),  32'(8'h0F));
    chk("burst_beats", 32'(out_beats), 32'(3));
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Back-pressure then simultaneous handshakes
    beat(1'b1, 3'd1, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1);
    held = out_data;
    chk("bp_first", 32'(held), 32'(8'h0F));
    for (int k = 0; k < 3; k++) begin
      beat(1'b1, 3'd2, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_stable", 32'(out_data), 32'(8'h0F));
    end
    beat(1'b1, 3'd2, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("bp_both_valid", 32'(out_valid), 32'(1));
    chk("bp_both_data",  32'(out_data),  32'(8'h33));
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // 20-beat AND burst: counter saturates, data keeps folding
    beat(1'b1, 3'd1, 8'hAA, 8'hAA, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) beat(1'b1, 3'd0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 3'd0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1);
    chk("sat_data",  32'(out_data),  32'(8'hAA));
    chk("sat_beats", 32'(out_beats), 32'(15));
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Reset mid-burst discards everything
    beat(1'b1, 3'd2, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 3'd2, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1);
    do_reset(1);
    beat(1'b1, 3'd2, 8'h10, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("midrst_data",  32'(out_data),  32'(8'h11));
    chk("midrst_beats", 32'(out_beats), 32'(1));
    beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("midrst_drain", 32'(out_valid), 32'(0));

    // Random traffic, including back-pressure during open bursts
    for (int k = 0; k < 400; k++) begin
      beat(1'($urandom_range(0, 3) != 0), 3'($urandom), W'($urandom), W'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
